// File: rtl/pipe_fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package pipe_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PAIR_W = 64;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [XLEN-1:0] PC_STEP   = 32'd8;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAITQ = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr2;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Combinational redirect detect and target select; slot 1 has priority over slot 2.
module fetch_redirect_sel
  import pipe_fetch_pkg::*;
(
  input  logic [1:0]      i_pcsrcd,
  input  logic [XLEN-1:0] i_pcbranchd,
  input  logic [XLEN-1:0] i_pcjumpd,
  input  logic [1:0]      i_pcsrcd2,
  input  logic [XLEN-1:0] i_pcbranchd2,
  input  logic [XLEN-1:0] i_pcjumpd2,
  output logic            o_redirect_c,
  output logic [XLEN-1:0] o_target_c
);

  logic            w_slot1;
  logic            w_slot2;
  logic [XLEN-1:0] w_tgt1;
  logic [XLEN-1:0] w_tgt2;

  assign w_slot1 = (i_pcsrcd  != 2'b00);
  assign w_slot2 = (i_pcsrcd2 != 2'b00);
  assign w_tgt1  = i_pcsrcd[1]  ? i_pcjumpd  : i_pcbranchd;
  assign w_tgt2  = i_pcsrcd2[1] ? i_pcjumpd2 : i_pcbranchd2;

  assign o_redirect_c = w_slot1 | w_slot2;
  assign o_target_c   = align_pc(w_slot1 ? w_tgt1 : w_tgt2);

endmodule

// File: rtl/pipe_fetch_unit.sv
// Dual-issue fetch stage: PC, single-outstanding imem requests, 2-entry pair queue.
// Optional FETCH_PERF_EN adds perf_pairs / perf_drops counters.
module pipe_fetch_unit
  import pipe_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallf,
  input  logic [1:0]        pcsrcd,
  input  logic [XLEN-1:0]   pcbranchd,
  input  logic [XLEN-1:0]   pcjumpd,
  input  logic [1:0]        pcsrcd2,
  input  logic [XLEN-1:0]   pcbranchd2,
  input  logic [XLEN-1:0]   pcjumpd2,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [PAIR_W-1:0] imem_rdata,
  output logic [XLEN-1:0]   instrf,
  output logic [XLEN-1:0]   instrf2,
  output logic [XLEN-1:0]   pcf,
  output logic [XLEN-1:0]   pcplus4f,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0]   perf_pairs,
  output logic [XLEN-1:0]   perf_drops,
`endif
  output logic              validf
);

  fetch_state_e    r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx;
  logic [XLEN-1:0] r_addr_q, w_addr_q_nx;
  fetch_entry_t    r_q [QDEPTH];
  fetch_entry_t    w_q_nx [QDEPTH];
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic            r_req, w_req_nx;
  logic [XLEN-1:0] r_addr, w_addr_nx;
  fetch_entry_t    r_head, w_head_nx;
  logic [XLEN-1:0] r_pcplus4, w_pcplus4_nx;
  logic            r_validf, w_validf_nx;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_pop, w_push, w_flush, w_drop_ack;
  fetch_entry_t    w_new_entry;

  fetch_redirect_sel u_redirect_sel (
    .i_pcsrcd     (pcsrcd),
    .i_pcbranchd  (pcbranchd),
    .i_pcjumpd    (pcjumpd),
    .i_pcsrcd2    (pcsrcd2),
    .i_pcbranchd2 (pcbranchd2),
    .i_pcjumpd2   (pcjumpd2),
    .o_redirect_c (w_redirect),
    .o_target_c   (w_target)
  );

  assign w_new_entry = '{instr: imem_rdata[31:0], instr2: imem_rdata[63:32], pc: r_pc};

  // Next-state, queue update and next registered outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_addr_q_nx = r_addr_q;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_drop_ack  = 1'b0;
    w_pop       = r_validf & ~stallf;

    unique case (r_state)
      IDLE: begin
        w_state_nx = FETCH;
        if (w_redirect) begin
          w_pc_nx = w_target;
          w_flush = 1'b1;
        end
      end
      FETCH: begin
        if (w_redirect) begin
          w_pc_nx = w_target;
          w_flush = 1'b1;
          if (imem_ack) begin
            w_drop_ack = 1'b1;
          end else begin
            w_addr_q_nx = r_pc;
            w_state_nx  = DROP;
          end
        end else if (imem_ack) begin
          w_push  = 1'b1;
          w_pc_nx = r_pc + PC_STEP;
        end
      end
      WAITQ: begin
        if (w_redirect) begin
          w_pc_nx    = w_target;
          w_flush    = 1'b1;
          w_state_nx = FETCH;
        end else if (w_pop) begin
          w_state_nx = FETCH;
        end
      end
      DROP: begin
        if (w_redirect) begin
          w_pc_nx = w_target;
          w_flush = 1'b1;
        end
        if (imem_ack) begin
          w_drop_ack = 1'b1;
          w_state_nx = FETCH;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    w_q_nx     = r_q;
    w_count_nx = r_count;
    if (w_flush) begin
      w_count_nx = '0;
    end else begin
      if (w_pop) begin
        w_q_nx[0]  = r_q[1];
        w_count_nx = w_count_nx - 2'd1;
      end
      // FETCH never holds two entries, so the write slot is 0 or 1.
      if (w_push) begin
        w_q_nx[w_count_nx[0]] = w_new_entry;
        w_count_nx            = w_count_nx + 2'd1;
      end
    end

    if (w_push && (w_count_nx == 2'd2)) begin
      w_state_nx = WAITQ;
    end

    w_req_nx  = (w_state_nx == FETCH) || (w_state_nx == DROP);
    w_addr_nx = '0;
    if (w_state_nx == DROP) begin
      w_addr_nx = w_addr_q_nx;
    end else if (w_state_nx == FETCH) begin
      w_addr_nx = w_pc_nx;
    end

    w_validf_nx  = (w_count_nx != '0);
    w_head_nx    = w_validf_nx ? w_q_nx[0] : '{instr: NOP_INSTR, instr2: NOP_INSTR, pc: '0};
    w_pcplus4_nx = w_validf_nx ? (w_q_nx[0].pc + 32'd4) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr_q  <= '0;
      r_q       <= '{default: '0};
      r_count   <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_head    <= '0;
      r_pcplus4 <= '0;
      r_validf  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_addr_q  <= w_addr_q_nx;
      r_q       <= w_q_nx;
      r_count   <= w_count_nx;
      r_req     <= w_req_nx;
      r_addr    <= w_addr_nx;
      r_head    <= w_head_nx;
      r_pcplus4 <= w_pcplus4_nx;
      r_validf  <= w_validf_nx;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instrf    = r_head.instr;
  assign instrf2   = r_head.instr2;
  assign pcf       = r_head.pc;
  assign pcplus4f  = r_pcplus4;
  assign validf    = r_validf;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_perf_pairs;
  logic [XLEN-1:0] r_perf_drops;

  // Drops count discarded acks plus entries lost to a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_pairs <= '0;
      r_perf_drops <= '0;
    end else begin
      r_perf_pairs <= r_perf_pairs + XLEN'(w_push);
      r_perf_drops <= r_perf_drops + XLEN'(w_drop_ack)
                      + (w_flush ? XLEN'(r_count) : '0);
    end
  end

  assign perf_pairs = r_perf_pairs;
  assign perf_drops = r_perf_drops;
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Randomized bench for pipe_fetch_unit with a queue-based reference model.
module tb_pipe_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallf;
  logic [1:0]  pcsrcd, pcsrcd2;
  logic [31:0] pcbranchd, pcjumpd, pcbranchd2, pcjumpd2;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [63:0] imem_rdata;
  logic [31:0] instrf, instrf2, pcf, pcplus4f;
  logic        validf;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_pairs, perf_drops;
`endif

  always #5 clk = ~clk;

  pipe_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallf     (stallf),
    .pcsrcd     (pcsrcd),
    .pcbranchd  (pcbranchd),
    .pcjumpd    (pcjumpd),
    .pcsrcd2    (pcsrcd2),
    .pcbranchd2 (pcbranchd2),
    .pcjumpd2   (pcjumpd2),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrf     (instrf),
    .instrf2    (instrf2),
    .pcf        (pcf),
    .pcplus4f   (pcplus4f),
`ifdef FETCH_PERF_EN
    .perf_pairs (perf_pairs),
    .perf_drops (perf_drops),
`endif
    .validf     (validf)
  );

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc;
  } ent_t;

  // Reference model: fetch PC, pair queue, pending-discard bookkeeping.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_first;
  logic        m_drop;
  logic [31:0] m_drop_addr;

  // Stimulus and memory responder.
  logic        s_stall;
  logic [1:0]  s_src1, s_src2;
  logic [31:0] s_br1, s_j1, s_br2, s_j2;
  int          lat;
  int          lat_cnt;
  logic        c_req;
  logic        c_ack;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic logic model_req();
    return !m_first && (m_drop || (m_q.size() < 2));
  endfunction

  task automatic cmp_model();
    logic ereq;
    ereq = model_req();
    chkb("imem_req", imem_req, ereq);
    if (m_first) chk("imem_addr_idle", imem_addr, 32'h0);
    else if (ereq) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
    if (m_q.size() > 0) begin
      chkb("validf", validf, 1'b1);
      chk("instrf", instrf, m_q[0].i1);
      chk("instrf2", instrf2, m_q[0].i2);
      chk("pcf", pcf, m_q[0].pc);
      chk("pcplus4f", pcplus4f, m_q[0].pc + 32'd4);
    end else begin
      chkb("validf", validf, 1'b0);
      chk("instrf_nop", instrf, 32'h0);
      chk("instrf2_nop", instrf2, 32'h0);
      chk("pcf_zero", pcf, 32'h0);
      chk("pcplus4f_zero", pcplus4f, 32'h0);
    end
  endtask

  task automatic model_update();
    logic        red;
    logic        ereq;
    logic [31:0] tgt;
    ent_t        e;
    red = (s_src1 != 2'b00) || (s_src2 != 2'b00);
    tgt = (s_src1 != 2'b00) ? (s_src1[1] ? s_j1 : s_br1) : (s_src2[1] ? s_j2 : s_br2);
    tgt[1:0] = 2'b00;
    ereq = model_req();
    if (c_req) lat_cnt = c_ack ? 0 : lat_cnt + 1;
    if (m_first) begin
      m_first = 1'b0;
      if (red) begin m_pc = tgt; m_q.delete(); end
    end else if (m_drop) begin
      if (c_ack) m_drop = 1'b0;
      if (red) m_pc = tgt;
    end else if (red) begin
      if (ereq && !c_ack) begin
        m_drop      = 1'b1;
        m_drop_addr = m_pc;
      end
      m_pc = tgt;
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && !s_stall) void'(m_q.pop_front());
      if (ereq && c_ack) begin
        e.i1 = memw(m_pc);
        e.i2 = memw(m_pc + 32'd4);
        e.pc = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 32'd8;
      end
    end
  endtask

  // Called at a negedge: compare, drive this cycle's inputs, advance across the rising edge.
  task automatic step();
    cmp_model();
    stallf     = s_stall;
    pcsrcd     = s_src1;  pcbranchd  = s_br1; pcjumpd  = s_j1;
    pcsrcd2    = s_src2;  pcbranchd2 = s_br2; pcjumpd2 = s_j2;
    c_req      = imem_req;
    if (rst_n && c_req && (lat_cnt >= lat)) begin
      imem_ack   = 1'b1;
      imem_rdata = {memw(imem_addr + 32'd4), memw(imem_addr)};
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = {$urandom, $urandom};
    end
    c_ack = imem_ack;
    @(posedge clk);
    if (rst_n) model_update();
    s_src1 = 2'b00;
    s_src2 = 2'b00;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = RPC;
    m_first = 1'b1;
    m_drop  = 1'b0;
    m_drop_addr = 32'h0;
    lat_cnt = 0;
    imem_ack = 1'b0;
    s_src1 = 2'b00;
    s_src2 = 2'b00;
    s_stall = 1'b0;
  endtask

  task automatic sync_pending(input string nm);
    int k;
    k = 0;
    while (!(imem_req === 1'b1 && lat_cnt == 1) && k < 40) begin
      step();
      k++;
    end
    chkb(nm, k < 40, 1'b1);
  endtask

  initial begin
    int          k;
    logic [31:0] a0;
    rst_n = 1'b0;
    stallf = 1'b0; pcsrcd = 2'b00; pcsrcd2 = 2'b00;
    pcbranchd = 32'h0; pcjumpd = 32'h0; pcbranchd2 = 32'h0; pcjumpd2 = 32'h0;
    imem_rdata = 64'h0;
    s_br1 = 32'h0; s_j1 = 32'h0; s_br2 = 32'h0; s_j2 = 32'h0;
    lat = 0;
    c_req = 1'b0;
    c_ack = 1'b0;
    model_reset();

    @(negedge clk);
    repeat (3) step();
    chkb("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chkb("rst_validf", validf, 1'b0);
    chk("rst_pcf", pcf, 32'h0);

    // Release; IDLE lasts one cycle, then request to RESET_PC.
    rst_n = 1'b1;
    chkb("idle_req", imem_req, 1'b0);
    step();
    chkb("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h400);
    step();
    chk("zw_pcf0", pcf, 32'h400);
    chk("zw_pc4_0", pcplus4f, 32'h404);
    step();
    chk("zw_pcf1", pcf, 32'h408);
    chk("zw_pc4_1", pcplus4f, 32'h40C);
    step();
    chk("zw_pcf2", pcf, 32'h410);
    chk("zw_pc4_2", pcplus4f, 32'h414);

    // Stall fills the queue and parks fetch.
    s_stall = 1'b1;
    repeat (4) step();
    chkb("waitq_req", imem_req, 1'b0);
    chk("stall_hold_pcf", pcf, 32'h410);
    s_stall = 1'b0;
    step();
    chk("stall_resume_pcf", pcf, 32'h418);
    repeat (3) step();

    // Redirect while a slow request is pending: old address held, ack discarded.
    lat = 3;
    sync_pending("sync_drop_timeout");
    a0 = imem_addr;
    s_src1 = 2'b01; s_br1 = 32'h800;
    step();
    k = 0;
    while (imem_addr !== 32'h800 && k < 10) begin
      chkb("drop_validf", validf, 1'b0);
      chk("drop_addr_hold", imem_addr, a0);
      step();
      k++;
    end
    chk("drop_next_addr", imem_addr, 32'h800);
    chkb("drop_next_req", imem_req, 1'b1);
    chkb("drop_next_validf", validf, 1'b0);

    // Zero-wait: redirect coincides with an ack in FETCH.
    lat = 0;
    repeat (4) step();
    s_src1 = 2'b10; s_j1 = 32'h900; s_src2 = 2'b01; s_br2 = 32'hA00;
    step();
    chk("prio_addr", imem_addr, 32'h900);
    chkb("prio_validf", validf, 1'b0);
    repeat (2) step();
    s_src1 = 2'b01; s_br1 = 32'h803;
    step();
    chk("ackredir_addr", imem_addr, 32'h800);
    chkb("ackredir_validf", validf, 1'b0);
    repeat (2) step();
    s_src2 = 2'b11; s_j2 = 32'h1234_5677;
    step();
    chk("slot2_jump_addr", imem_addr, 32'h1234_5674);

    // PC wraps modulo 2^32.
    s_src1 = 2'b11; s_j1 = 32'hFFFF_FFF0;
    step();
    step();
    chk("wrap_pcf0", pcf, 32'hFFFF_FFF0);
    step();
    chk("wrap_pcf1", pcf, 32'hFFFF_FFF8);
    chk("wrap_pc4_1", pcplus4f, 32'hFFFF_FFFC);
    step();
    chk("wrap_pcf2", pcf, 32'h0);
    chk("wrap_pc4_2", pcplus4f, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (lat_cnt == 0) lat = int'($urandom_range(0, 3));
      s_stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) begin
        s_src1 = 2'($urandom); s_br1 = $urandom; s_j1 = $urandom;
        s_src2 = 2'($urandom); s_br2 = $urandom; s_j2 = $urandom;
      end
      step();
    end

    // Asynchronous reset in the middle of a pending request.
    s_stall = 1'b0;
    lat = 3;
    sync_pending("sync_rst_timeout");
    #2 rst_n = 1'b0;
    #1;
    chkb("async_rst_req", imem_req, 1'b0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chkb("async_rst_validf", validf, 1'b0);
    model_reset();
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    lat = 1;
    step();
    chkb("rerst_req", imem_req, 1'b1);
    chk("rerst_addr", imem_addr, 32'h400);
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
